// File: rtl/pi_digit_scroller_pkg.sv
// Shared types, state encoding and modular address helpers for the pi digit scroller.
package pi_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    localparam int PI_MAX_INDEX = 27640;

    function automatic logic [31:0] wrap_inc(input logic [31:0] a, input logic [31:0] max_idx);
        return (a >= max_idx) ? 32'd0 : a + 32'd1;
    endfunction

    function automatic logic [31:0] wrap_dec(input logic [31:0] a, input logic [31:0] max_idx);
        return (a == 32'd0) ? max_idx : a - 32'd1;
    endfunction

endpackage

// File: rtl/pi_digit_scroller_if.sv
// Digit ROM read bus: the scroller drives the address, the ROM returns a digit a fixed latency later.
interface pi_digit_scroller_if #(
    parameter int INDEX_W = 17
);
    logic [INDEX_W-1:0] rd_addr;
    pi_pkg::digit_t     rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/pi_digit_scroller_step_tick.sv
// Step prescaler and pending-step merge: automatic ticks and manual requests collapse into one flag.
module pi_step_tick #(
    parameter int STEP_CYCLES = 33554432
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    input  logic step_req,
    input  logic take,
    output logic pending
);
    localparam int TICK_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);

    logic [TICK_W-1:0] r_tick;
    logic              r_pending;
    logic              w_auto;

    assign w_auto = ~pause && (r_tick == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (!pause) begin
                r_tick <= w_auto ? '0 : r_tick + 1'b1;
            end
            // A new step landing in the same cycle the old one is taken must survive.
            r_pending <= w_auto | step_req | (r_pending & ~take);
        end
    end

    assign pending = r_pending;

endmodule

// File: rtl/pi_digit_scroller.sv
// Scrolling window of N_DIGITS pi digits fetched from a latency-FETCH_LATENCY ROM, committed atomically.
// Define PI_SCROLL_DECPOINT_EN to mark the committed position of address 0 in dp_mask.
module pi_digit_scroller
    import pi_pkg::*;
#(
    parameter int N_DIGITS      = 8,
    parameter int INDEX_W       = 17,
    parameter int MAX_INDEX     = PI_MAX_INDEX,
    parameter int STEP_CYCLES   = 33554432,
    parameter int FETCH_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pause,
    input  logic                  dir,
    input  logic                  step_req,
    pi_digit_scroller_if.master   rom,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   dp_mask,
    output logic [INDEX_W-1:0]    base,
    output logic                  frame_valid
);
    localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIGITS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_pending;
    logic                     w_take;
    logic                     w_fetch_adv;
    logic                     w_cap;
    logic [INDEX_W-1:0]       r_next_base;
    logic [INDEX_W-1:0]       r_rd_addr;
    logic [INDEX_W-1:0]       r_base;
    logic [INDEX_W-1:0]       w_stepped;
    logic [INDEX_W-1:0]       w_addr_inc;
    logic [SLOT_W-1:0]        r_issue_cnt;
    logic [SLOT_W-1:0]        r_cap_cnt;
    logic [FETCH_LATENCY-1:0] r_vld;
    digit_t                   r_shadow [N_DIGITS];
    logic [4*N_DIGITS-1:0]    w_shadow_flat;
    logic [4*N_DIGITS-1:0]    r_digits;
    logic                     r_frame_valid;

    pi_step_tick #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_step_tick (
        .clk      (clk),
        .rst      (rst),
        .pause    (pause),
        .step_req (step_req),
        .take     (w_take),
        .pending  (w_pending)
    );

    assign w_stepped  = dir ? INDEX_W'(wrap_dec(32'(r_next_base), 32'(MAX_INDEX)))
                            : INDEX_W'(wrap_inc(32'(r_next_base), 32'(MAX_INDEX)));
    assign w_addr_inc = INDEX_W'(wrap_inc(32'(r_rd_addr), 32'(MAX_INDEX)));
    assign w_cap      = r_vld[FETCH_LATENCY-1];

    always_comb begin
        w_shadow_flat = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_shadow_flat[4*i +: 4] = r_shadow[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_fetch_adv = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (r_issue_cnt == SLOT_LAST) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_fetch_adv = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_cap && (r_cap_cnt == SLOT_LAST)) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_FETCH;
        endcase
    end

    // rd_addr is loaded with the stepped base on the accept edge, so FETCH cycle k already shows address k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_base   <= '0;
            r_rd_addr     <= '0;
            r_issue_cnt   <= '0;
            r_cap_cnt     <= '0;
            r_vld         <= '0;
            r_digits      <= '0;
            r_base        <= '0;
            r_frame_valid <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            r_vld[0] <= (r_state == ST_FETCH);
            for (int i = 1; i < FETCH_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_frame_valid <= (r_state == ST_COMMIT);
            if (w_take) begin
                r_next_base <= w_stepped;
                r_rd_addr   <= w_stepped;
                r_issue_cnt <= '0;
                r_cap_cnt   <= '0;
            end
            if (w_fetch_adv) begin
                r_rd_addr   <= w_addr_inc;
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_cap) begin
                r_shadow[r_cap_cnt] <= rom.rd_data;
                r_cap_cnt           <= r_cap_cnt + 1'b1;
            end
            if (r_state == ST_COMMIT) begin
                r_digits <= w_shadow_flat;
                r_base   <= r_next_base;
            end
        end
    end

`ifdef PI_SCROLL_DECPOINT_EN
    logic [N_DIGITS-1:0] r_dp_shadow;
    logic [N_DIGITS-1:0] r_dp_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dp_shadow <= '0;
            r_dp_mask   <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_dp_shadow[r_issue_cnt] <= (r_rd_addr == '0);
            end
            if (r_state == ST_COMMIT) begin
                r_dp_mask <= r_dp_shadow;
            end
        end
    end

    assign dp_mask = r_dp_mask;
`else
    assign dp_mask = '0;
`endif

    assign rom.rd_addr = r_rd_addr;
    assign digits      = r_digits;
    assign base        = r_base;
    assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_pi_digit_scroller.sv
// Directed bench for pi_digit_scroller: 8 digits, 32-cycle tick, latency-2 ROM returning addr%10, MAX_INDEX 99.
module tb_pi_digit_scroller;

    localparam int N    = 8;
    localparam int IW   = 17;
    localparam int MAXI = 99;
    localparam int STEP = 32;
    localparam int LAT  = 2;

`ifdef PI_SCROLL_DECPOINT_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    typedef struct {
        logic          dir;
        logic [IW-1:0] base;
        logic [31:0]   digits;
        logic [7:0]    dp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          pause;
    logic          dir;
    logic          step_req;
    logic [4*N-1:0] digits;
    logic [N-1:0]  dp_mask;
    logic [IW-1:0] base;
    logic          frame_valid;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_commits = 0;

    pi_digit_scroller_if #(.INDEX_W(IW)) rom_if ();

    pi_digit_scroller #(
        .N_DIGITS      (N),
        .INDEX_W       (IW),
        .MAX_INDEX     (MAXI),
        .STEP_CYCLES   (STEP),
        .FETCH_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .dir         (dir),
        .step_req    (step_req),
        .rom         (rom_if),
        .digits      (digits),
        .dp_mask     (dp_mask),
        .base        (base),
        .frame_valid (frame_valid)
    );

    always #5 clk = ~clk;

    logic [3:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= 4'(rom_if.rd_addr % 10);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_if.rd_data = rom_pipe[LAT-1];

    always @(negedge clk) if (frame_valid === 1'b1) n_commits++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(input int limit, output int ncyc);
        ncyc = 0;
        do begin
            @(negedge clk);
            ncyc++;
        end while (frame_valid !== 1'b1 && ncyc < limit);
        n_checks++;
        if (frame_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL wait_frame: got no frame_valid, expected one within %0d cycles", limit);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_digits"}, digits, 32'h0);
        chk({tag, "_dp"}, 32'(dp_mask), 32'h0);
        chk({tag, "_base"}, 32'(base), 32'h0);
        chk({tag, "_rdaddr"}, 32'(rom_if.rd_addr), 32'h0);
        chk({tag, "_fv"}, 32'(frame_valid), 32'h0);
    endtask

    // Caller is at a negedge; releases reset and follows the automatic initial load.
    task automatic check_startup(input string tag);
        int n;
        rst = 1'b0;
        #1;
        chk({tag, "_addr0"}, 32'(rom_if.rd_addr), 32'd0);
        for (int k = 1; k < N; k++) begin
            @(negedge clk);
            chk($sformatf("%s_addr%0d", tag, k), 32'(rom_if.rd_addr), k);
            chk($sformatf("%s_fv%0d", tag, k), 32'(frame_valid), 32'd0);
        end
        wait_frame(40, n);
        chk({tag, "_latency"}, (N - 1) + n, 32'd11);
        chk({tag, "_base"}, 32'(base), 32'd0);
        chk({tag, "_digits"}, digits, 32'h7654_3210);
        chk({tag, "_dp"}, 32'(dp_mask), DP_EN ? 32'h01 : 32'h00);
    endtask

    // Caller is at a negedge with the FSM idle; returns cycles from the step pulse to the visible frame.
    task automatic do_step(input logic d, output int lat);
        int n;
        dir      = d;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_frame(40, n);
        lat = n + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        int   n;
        int   lat;
        int   c0;

        tbl[0] = '{1'b1, 17'd4,  32'h1098_7654, 8'h00};
        tbl[1] = '{1'b1, 17'd3,  32'h0987_6543, 8'h00};
        tbl[2] = '{1'b1, 17'd2,  32'h9876_5432, 8'h00};
        tbl[3] = '{1'b1, 17'd1,  32'h8765_4321, 8'h00};
        tbl[4] = '{1'b1, 17'd0,  32'h7654_3210, 8'h01};
        tbl[5] = '{1'b1, 17'd99, 32'h6543_2109, 8'h02};
        tbl[6] = '{1'b1, 17'd98, 32'h5432_1098, 8'h04};
        tbl[7] = '{1'b0, 17'd99, 32'h6543_2109, 8'h02};
        tbl[8] = '{1'b0, 17'd0,  32'h7654_3210, 8'h01};
        tbl[9] = '{1'b0, 17'd1,  32'h8765_4321, 8'h00};

        rst      = 1'b1;
        pause    = 1'b0;
        dir      = 1'b0;
        step_req = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        check_startup("por");

        // Free run: the initial load skips IDLE, so the first gap is one cycle longer.
        wait_frame(40, n);
        chk("run_gap1", n, 32'd33);
        chk("run_base1", 32'(base), 32'd1);
        wait_frame(40, n);
        chk("run_gap2", n, 32'd32);
        chk("run_base2", 32'(base), 32'd2);
        chk("run_digits2", digits, 32'h9876_5432);

        // Auto tick fired 12 cycles ago; start a manual fetch that the next tick and two requests overlap.
        #1;
        c0 = n_commits;
        repeat (15) @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (11) @(negedge clk);
        chk("merge_base_a", 32'(base), 32'd3);
        chk("merge_digits_a", digits, 32'h0987_6543);
        repeat (18) @(negedge clk);
        #1;
        chk("merge_count", n_commits - c0, 32'd2);
        chk("merge_base_b", 32'(base), 32'd4);
        chk("merge_digits_b", digits, 32'h1098_7654);
        pause = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        chk("merge_count_late", n_commits - c0, 32'd2);

        c0 = n_commits;
        repeat (200) @(negedge clk);
        #1;
        chk("pause_no_commit", n_commits - c0, 32'd0);
        chk("pause_base_hold", 32'(base), 32'd4);
        @(negedge clk);
        do_step(1'b0, lat);
        chk("pause_step_lat", lat, 32'd13);
        chk("pause_step_base", 32'(base), 32'd5);
        chk("pause_step_digits", digits, 32'h2109_8765);
        repeat (30) @(negedge clk);
        #1;
        chk("pause_step_count", n_commits - c0, 32'd1);

        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            do_step(tbl[i].dir, lat);
            chk($sformatf("tbl%0d_lat", i), lat, 32'd13);
            chk($sformatf("tbl%0d_base", i), 32'(base), 32'(tbl[i].base));
            chk($sformatf("tbl%0d_digits", i), digits, tbl[i].digits);
            chk($sformatf("tbl%0d_dp", i), 32'(dp_mask), DP_EN ? 32'(tbl[i].dp) : 32'h0);
        end

        // Step from base 1, then reset while the window is draining.
        dir      = 1'b0;
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("mid");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_hold_fv%0d", k), 32'(frame_valid), 32'd0);
            chk($sformatf("mid_hold_digits%0d", k), digits, 32'h0);
        end
        check_startup("rel");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pi_digit_scroller.md
# pi_digit_scroller

Parametrised successor to the fixed 8-digit pi viewer. Maintains a window of `N_DIGITS` consecutive digits from a latency-`FETCH_LATENCY` digit ROM. Scrolls the window forward or backward on a programmable tick, or on a manual step request, with pause. Each window is loaded into a shadow buffer and committed atomically, so the display driver downstream never shows a half-updated (torn) frame.

## Interface
- `N_DIGITS`, 8, window width in digits (1..16)
- `INDEX_W`, 17, digit-address width
- `MAX_INDEX`, 27640, last valid digit address; addresses wrap modulo `MAX_INDEX+1`
- `STEP_CYCLES`, 33554432, clocks between automatic steps (≥ `N_DIGITS+FETCH_LATENCY+2`)
- `FETCH_LATENCY`, 1, ROM read latency in clocks (1..4)
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `pause`  in  1  level; suppresses automatic steps, tick counter holds
- `dir`  in  1  0 = forward (base+1), 1 = backward (base−1); sampled when a step is applied
- `step_req`  in  1  single-cycle pulse; requests one manual step regardless of `pause`
- `rd_addr`  out  INDEX_W  ROM address
- `rd_data`  in  4  ROM digit, valid `FETCH_LATENCY` clocks after `rd_addr`
- `digits`  out  4*N_DIGITS  committed window; nibble i (`[4i+3:4i]`) = digit at base+i, i=0 leftmost
- `dp_mask`  out  N_DIGITS  decimal-point enables (see Configuration)
- `base`  out  INDEX_W  address of nibble 0 of the committed window
- `frame_valid`  out  1  one-cycle pulse on every commit

## Operation
- FSM states: IDLE, FETCH, DRAIN, COMMIT.
- Reset: `digits`=0, `dp_mask`=0, `base`=0, `rd_addr`=0, `frame_valid`=0, tick=0, pending=0, state=FETCH. An initial window is loaded automatically after reset deasserts.
- Tick counter:
  - Increments when `pause`=0.
  - At `STEP_CYCLES-1` it wraps to 0 and raises an automatic step.
- Step sources: automatic step or `step_req`. Either source sets `pending`; multiple steps while pending collapse to one.
- IDLE: if `pending`, apply the step to the working base (`next_base`), clear `pending`, and go to FETCH.
- FETCH:
  - Issue `rd_addr` = `next_base`+k (mod `MAX_INDEX+1`) for k = 0..N_DIGITS−1, one per cycle.
  - Go to DRAIN after the last address.
- DRAIN: wait until all `N_DIGITS` returns have been captured into the shadow buffer (slot k receives the response to address k).
- COMMIT:
  - `digits` ← shadow, `base` ← `next_base`, `frame_valid`=1 for one cycle.
  - Go to IDLE.
- Wrap rules:
  - Forward from `MAX_INDEX` → 0.
  - Backward from 0 → `MAX_INDEX`.
  - Window addresses wrap identically, so a window straddling the end shows `MAX_INDEX` followed by 0.
- A step arriving during FETCH/DRAIN/COMMIT stays pending and is serviced from IDLE after the commit. It is never dropped and never disturbs the current fetch.
- Simultaneous `step_req` and automatic tick count as one step.
- Asynchronous `rst` mid-fetch discards the shadow buffer. All outputs return to their reset values immediately.

## Timing
- Step accepted in IDLE → first `rd_addr` next cycle.
- First `rd_addr` → `frame_valid` after exactly `N_DIGITS+FETCH_LATENCY+1` clocks.
- `digits`, `base`, `dp_mask` change only in the COMMIT cycle, all together.
- All outputs are registered. `rd_data` is sampled with a `FETCH_LATENCY`-deep valid shift register.
- `rd_addr` holds its last value outside FETCH.

## Configuration
- `PI_SCROLL_DECPOINT_EN` defined:
  - `dp_mask[i]`=1 exactly when committed address base+i = 0, marking the "3." position.
  - Computed during FETCH and committed with `digits`.
- Not defined: `dp_mask` is constant 0 and the comparison logic is absent.

## Structure
- Shared package `pi_pkg`:
  - `digit_t` (4-bit).
  - FSM state enum.
  - `PI_MAX_INDEX` default constant.
  - Wrap-increment and wrap-decrement functions.
- One sub-module: `pi_step_tick`, containing the prescaler, `pause` handling, and the step/pending merge.

## Test plan
Bench settings: `N_DIGITS`=8, `STEP_CYCLES`=32, `FETCH_LATENCY`=2, `MAX_INDEX`=99; ROM model returns `addr%10`.
- Reset release → `frame_valid` 11 clocks after the first `rd_addr`; `digits` = 0,1,…,7 (nibble0..7); `base`=0.
- Free run with `pause`=0 → a commit every 32 clocks; third window has `base`=2 and digits 2..9.
- `dir`=1 from `base`=0 → `base`=99; digits 9,0,1,…,6; with the macro, `dp_mask`=8'b0000_0010.
- `pause`=1 for 200 clocks, then a `step_req` pulse → exactly one commit, `base`+1; no other commits during the pause.
- `step_req` pulsed twice during FETCH plus an automatic tick → exactly one extra step after the current commit.
- `rst` asserted in the middle of DRAIN → `digits`=0, `frame_valid` stays 0, and the fetch restarts from `base` 0 after release.
